// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb-defusal puzzle blocks.
// Contents:
//   - GS_SEQUENCE: the game FSM state that requests a sequence key.
//   - LEVEL_* : difficulty level encodings.
//   - seqkey_state_t: the sequence_key_gen controller states.
//   - seqkey_active_len(): key length for a given digit count and level.
package bomb_pkg;

    localparam logic [6:0] GS_SEQUENCE = 7'h10;

    localparam logic [1:0] LEVEL_EASY   = 2'd0;
    localparam logic [1:0] LEVEL_NORMAL = 2'd1;
    localparam logic [1:0] LEVEL_HARD   = 2'd2;
    localparam logic [1:0] LEVEL_EXPERT = 2'd3;

    typedef enum logic [1:0] {
        SK_IDLE = 2'd0,
        SK_FILL = 2'd1,
        SK_HOLD = 2'd2,
        SK_DONE = 2'd3
    } seqkey_state_t;

    // Longest key at the top level, three digits shorter at level 0, never
    // shorter than a single digit.
    function automatic int seqkey_active_len(input int num_digits, input logic [1:0] level);
        int len;
        len = num_digits - 3 + int'(level);
        return (len < 1) ? 1 : len;
    endfunction

endpackage

// File: rtl/sequence_key_gen_if.sv
// Key-generation stream interface.
// Signals:
//   data_in      LFSR word feeding the generator
//   data_valid   data_in is fresh this cycle
//   key_ready    consumer accepts the finished key
//   sequence_key key, digit 0 in the MSBs, each digit one-hot-low
//   key_len      number of active digits
//   key_valid    key complete and stable
//   busy         generator is collecting digits
// Modports: master = LFSR/consumer side, slave = generator.
interface sequence_key_gen_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_SYMBOLS = 4,
    parameter int DATA_W      = 8
);
    localparam int KEY_W = NUM_DIGITS * NUM_SYMBOLS;
    localparam int LEN_W = $clog2(NUM_DIGITS + 1);

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              key_ready;
    logic [KEY_W-1:0]  sequence_key;
    logic [LEN_W-1:0]  key_len;
    logic              key_valid;
    logic              busy;

    modport master (
        output data_in, data_valid, key_ready,
        input  sequence_key, key_len, key_valid, busy
    );

    modport slave (
        input  data_in, data_valid, key_ready,
        output sequence_key, key_len, key_valid, busy
    );

endinterface

// File: rtl/symbol_onehot_low.sv
// Combinational symbol encoder: drives every switch position high except the
// one selected by the symbol.
// Ports:
//   sym_i    symbol index, SYM_W bits
//   digit_o  one-hot-low digit, NUM_SYMBOLS bits
module symbol_onehot_low #(
    parameter  int NUM_SYMBOLS = 4,
    localparam int SYM_W       = $clog2(NUM_SYMBOLS)
) (
    input  logic [SYM_W-1:0]       sym_i,
    output logic [NUM_SYMBOLS-1:0] digit_o
);

    always_comb begin
        digit_o        = '1;
        digit_o[sym_i] = 1'b0;
    end

endmodule

// File: rtl/sequence_key_gen.sv
// Sequence puzzle key generator. Draws one symbol per valid LFSR word,
// stores it one-hot-low in the key register and offers the finished key on a
// valid/ready handshake. Key length follows the difficulty level.
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   game_state_i   top-level game FSM state; GS_SEQUENCE starts a key
//   level_state_i  difficulty level 0..3, sampled when a key starts
//   key_if         slave side of sequence_key_gen_if (data in, key out)
// Build option:
//   SEQKEY_NO_REPEAT_EN  when defined, a symbol equal to the previous digit's
//                        symbol is discarded (digit 0 always accepted).
//
// state   | meaning
// --------+-------------------------------------------------------------
// SK_IDLE | waiting for the trigger; last key (if any) still displayed
// SK_FILL | writing one digit per accepted word
// SK_HOLD | key_valid high, key frozen until key_ready
// SK_DONE | key delivered and retained; waiting for the trigger to drop
module sequence_key_gen
    import bomb_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int NUM_SYMBOLS = 4,
    parameter int DATA_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          game_state_i,
    input  logic [1:0]          level_state_i,
    sequence_key_gen_if.slave   key_if
);

    localparam int SYM_W = $clog2(NUM_SYMBOLS);
    localparam int KEY_W = NUM_DIGITS * NUM_SYMBOLS;
    localparam int LEN_W = $clog2(NUM_DIGITS + 1);

    seqkey_state_t      state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
`ifdef SEQKEY_NO_REPEAT_EN
    logic [SYM_W-1:0]   prev_sym_q, prev_sym_d;
`endif

    logic                   trig;
    logic [SYM_W-1:0]       sym;
    logic [NUM_SYMBOLS-1:0] digit_enc;
    logic [LEN_W-1:0]       act_len;
    logic                   accept;
    logic                   unused_data_bits;

    assign trig    = (game_state_i == GS_SEQUENCE);
    assign sym     = key_if.data_in[SYM_W-1:0];
    assign act_len = LEN_W'(seqkey_active_len(NUM_DIGITS, level_state_i));

    // Only the low symbol bits of the LFSR word are meaningful.
    assign unused_data_bits = ^key_if.data_in;

    symbol_onehot_low #(
        .NUM_SYMBOLS (NUM_SYMBOLS)
    ) u_enc (
        .sym_i   (sym),
        .digit_o (digit_enc)
    );

    always_comb begin
        accept = key_if.data_valid;
`ifdef SEQKEY_NO_REPEAT_EN
        if ((idx_q != '0) && (sym == prev_sym_q)) begin
            accept = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef SEQKEY_NO_REPEAT_EN
        prev_sym_d = prev_sym_q;
`endif
        unique case (state_q)
            SK_IDLE: begin
                if (trig) begin
                    len_d   = act_len;
                    key_d   = '1;
                    idx_d   = '0;
                    state_d = SK_FILL;
                end
            end
            SK_FILL: begin
                if (!trig) begin
                    // Abandoned key: blank the display and report no digits.
                    key_d   = '1;
                    len_d   = '0;
                    idx_d   = '0;
                    state_d = SK_IDLE;
                end else if (accept) begin
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        if (idx_q == LEN_W'(d)) begin
                            key_d[(NUM_DIGITS-1-d)*NUM_SYMBOLS +: NUM_SYMBOLS] = digit_enc;
                        end
                    end
                    idx_d = idx_q + LEN_W'(1);
`ifdef SEQKEY_NO_REPEAT_EN
                    prev_sym_d = sym;
`endif
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = SK_HOLD;
                    end
                end
            end
            SK_HOLD: begin
                // Trigger loss is deliberately ignored until the handshake ends.
                if (key_if.key_ready) begin
                    state_d = SK_DONE;
                end
            end
            SK_DONE: begin
                if (!trig) begin
                    state_d = SK_IDLE;
                end
            end
            default: state_d = SK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SK_IDLE;
            key_q   <= '1;
            len_q   <= '0;
            idx_q   <= '0;
`ifdef SEQKEY_NO_REPEAT_EN
            prev_sym_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
`ifdef SEQKEY_NO_REPEAT_EN
            prev_sym_q <= prev_sym_d;
`endif
        end
    end

    assign key_if.sequence_key = key_q;
    assign key_if.key_len      = len_q;
    assign key_if.key_valid    = (state_q == SK_HOLD);
    assign key_if.busy         = (state_q == SK_FILL);

endmodule

// File: tb/tb_sequence_key_gen.sv
`timescale 1ns/1ps
module tb_sequence_key_gen;
    import bomb_pkg::*;

    localparam int ND = 4;
    localparam int NS = 4;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] game_state;
    logic [1:0] level_state;

    int checks   = 0;
    int failures = 0;

    int unsigned acc_syms[$];
    int          cur_len;
    logic [7:0]  fw[8];
    int          nsent;

    sequence_key_gen_if #(.NUM_DIGITS(ND), .NUM_SYMBOLS(NS), .DATA_W(DW)) kif ();

    sequence_key_gen #(.NUM_DIGITS(ND), .NUM_SYMBOLS(NS), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .game_state_i  (game_state),
        .level_state_i (level_state),
        .key_if        (kif)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_len(input int lvl);
        int v;
        v = ND - 3 + lvl;
        return (v < 1) ? 1 : v;
    endfunction

    // Key from the accepted symbol list: all ones, then clear bit `sym` of
    // each active digit (digit 0 occupies the top nibble).
    function automatic logic [15:0] model_key(input int len);
        logic [15:0] k;
        k = '1;
        for (int i = 0; i < len; i++) begin
            k[(ND-1-i)*NS + int'(acc_syms[i])] = 1'b0;
        end
        return k;
    endfunction

    task automatic build_key(input int lvl, input int gap_min, input int gap_max,
                             input bit preready, input int nfixed);
        int          k;
        logic [7:0]  w;
        int unsigned s;
        bit          rej;
        cur_len = exp_len(lvl);
        acc_syms.delete();
        nsent = 0;
        level_state    = 2'(lvl);
        game_state     = GS_SEQUENCE;
        kif.key_ready  = preready;
        kif.data_valid = 1'b0;
        @(negedge clk);
        check_val("fill_busy", kif.busy, 1);
        check_val("fill_len", kif.key_len, cur_len);
        check_val("fill_key_clear", kif.sequence_key, 16'hFFFF);
        while (acc_syms.size() < cur_len && nsent < 64) begin
            k = $urandom_range(gap_max, gap_min);
            repeat (k) begin
                kif.data_valid = 1'b0;
                kif.data_in    = 8'($urandom);
                @(negedge clk);
                check_val("stall_kv", kif.key_valid, 0);
            end
            w = (nsent < nfixed) ? fw[nsent] : 8'($urandom);
            kif.data_in    = w;
            kif.data_valid = 1'b1;
            nsent++;
            @(negedge clk);
            kif.data_valid = 1'b0;
            s   = int'(w) % NS;
            rej = 1'b0;
`ifdef SEQKEY_NO_REPEAT_EN
            rej = (acc_syms.size() > 0) && (acc_syms[$] == s);
`endif
            if (!rej) acc_syms.push_back(s);
            check_val("kv_step", kif.key_valid, (acc_syms.size() == cur_len));
        end
        check_val("key", kif.sequence_key, model_key(cur_len));
        check_val("key_len", kif.key_len, cur_len);
    endtask

    task automatic hold_release(input int hold, input bit preready);
        logic [15:0] kexp;
        kexp = model_key(cur_len);
        if (!preready) begin
            repeat (hold) begin
                @(negedge clk);
                check_val("hold_kv", kif.key_valid, 1);
                check_val("hold_key", kif.sequence_key, kexp);
            end
            kif.key_ready = 1'b1;
        end
        @(negedge clk);
        check_val("release_kv", kif.key_valid, 0);
        check_val("done_key", kif.sequence_key, kexp);
        check_val("done_len", kif.key_len, cur_len);
        kif.key_ready = 1'b0;
        // Trigger still high and data arriving: no second key may start.
        repeat (3) begin
            kif.data_in    = 8'($urandom);
            kif.data_valid = 1'b1;
            @(negedge clk);
            check_val("done_busy", kif.busy, 0);
            check_val("done_kv", kif.key_valid, 0);
            check_val("done_hold_key", kif.sequence_key, kexp);
        end
        kif.data_valid = 1'b0;
        game_state = 7'h00;
        @(negedge clk);
        kif.data_valid = 1'b1;
        kif.data_in    = 8'($urandom);
        @(negedge clk);
        kif.data_valid = 1'b0;
        check_val("idle_key", kif.sequence_key, kexp);
        check_val("idle_busy", kif.busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        game_state     = 7'h00;
        level_state    = 2'd0;
        kif.data_in    = '0;
        kif.data_valid = 1'b0;
        kif.key_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_key", kif.sequence_key, 16'hFFFF);
        check_val("rst_len", kif.key_len, 0);
        check_val("rst_kv", kif.key_valid, 0);
        check_val("rst_busy", kif.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full-length key, then 10 cycles of backpressure.
        fw[0] = 8'd0; fw[1] = 8'd1; fw[2] = 8'd2; fw[3] = 8'd3;
        build_key(3, 0, 0, 1'b0, 4);
        check_val("full_key_const", kif.sequence_key, 16'hEDB7);
        check_val("full_nsent", nsent, 4);
        hold_release(10, 1'b0);

        // Shortest key, key_ready high before key_valid.
        fw[0] = 8'd2;
        build_key(0, 0, 0, 1'b1, 1);
        check_val("short_key_const", kif.sequence_key, 16'hBFFF);
        check_val("short_len_const", kif.key_len, 1);
        hold_release(0, 1'b1);

        // Repeat rule.
        fw[0] = 8'd1; fw[1] = 8'd1; fw[2] = 8'd2; fw[3] = 8'd3; fw[4] = 8'd0;
        build_key(3, 0, 0, 1'b0, 5);
`ifdef SEQKEY_NO_REPEAT_EN
        check_val("repeat_key_const", kif.sequence_key, 16'hDB7E);
        check_val("repeat_nsent", nsent, 5);
`else
        check_val("repeat_key_const", kif.sequence_key, 16'hDDB7);
        check_val("repeat_nsent", nsent, 4);
`endif
        hold_release(2, 1'b0);

        // Three-cycle gaps between words.
        fw[0] = 8'd0; fw[1] = 8'd1; fw[2] = 8'd2; fw[3] = 8'd3;
        build_key(3, 3, 3, 1'b0, 4);
        check_val("stall_key_const", kif.sequence_key, 16'hEDB7);
        hold_release(1, 1'b0);

        // Trigger dropped after two digits.
        level_state = 2'd3;
        game_state  = GS_SEQUENCE;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            kif.data_in    = 8'(i);
            kif.data_valid = 1'b1;
            @(negedge clk);
        end
        kif.data_valid = 1'b0;
        check_val("pre_abort_key", kif.sequence_key, 16'hEDFF);
        game_state = 7'h00;
        @(negedge clk);
        check_val("abort_key", kif.sequence_key, 16'hFFFF);
        check_val("abort_len", kif.key_len, 0);
        check_val("abort_busy", kif.busy, 0);
        check_val("abort_kv", kif.key_valid, 0);

        // Asynchronous reset in the middle of FILL.
        game_state = GS_SEQUENCE;
        @(negedge clk);
        kif.data_in    = 8'd1;
        kif.data_valid = 1'b1;
        @(negedge clk);
        kif.data_valid = 1'b0;
        check_val("pre_rst_key", kif.sequence_key, 16'hDFFF);
        check_val("pre_rst_busy", kif.busy, 1);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_key", kif.sequence_key, 16'hFFFF);
        check_val("async_rst_len", kif.key_len, 0);
        check_val("async_rst_kv", kif.key_valid, 0);
        check_val("async_rst_busy", kif.busy, 0);
        game_state = 7'h00;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized keys.
        for (int it = 0; it < 20; it++) begin
            bit pr;
            pr = 1'($urandom_range(1, 0));
            build_key(int'($urandom_range(3, 0)), 0, 3, pr, 0);
            hold_release(int'($urandom_range(6, 0)), pr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequence_key_gen.md
# sequence_key_gen

Parametrised generator for the bomb-defusal sequence puzzle key. It draws one symbol per valid LFSR word, encodes each symbol one-hot-low across `NUM_SYMBOLS` switch positions and holds the key with a valid/ready handshake. It sits between the LFSR and the seven-segment display driver and the sequence checker. Key length scales with `level_state`, and an optional compile-time rule forbids consecutive repeated symbols.

## Interface
- `NUM_DIGITS`, 4, maximum key length in symbols (1..8).
- `NUM_SYMBOLS`, 4, switch positions per digit (power of two, 2..16).
- `DATA_W`, 8, LFSR word width (must be at least `SYM_W`).
- `SYM_W`, `$clog2(NUM_SYMBOLS)`, derived; not to be overridden.
- `clk` input 1 — system clock; all logic on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `game_state` input 7 — top-level game FSM state.
- `level_state` input 2 — difficulty level, 0..3.
- `data_in` input DATA_W — LFSR word.
- `data_valid` input 1 — `data_in` holds a fresh word this cycle.
- `key_ready` input 1 — consumer accepts the key.
- `sequence_key` output NUM_DIGITS*NUM_SYMBOLS — digit 0 in the MSBs; each digit is one-hot-low.
- `key_len` output $clog2(NUM_DIGITS+1) — number of active digits.
- `key_valid` output 1 — key complete and stable.
- `busy` output 1 — high in FILL.

## Operation
- The trigger is `game_state == GS_SEQUENCE` (7'h10).
- Active length L is computed from `level_state` at trigger: L = max(1, NUM_DIGITS - 3 + level_state).
- Symbol s = `data_in[SYM_W-1:0]`. Its digit value is all-ones except bit s, which is 0.
- Unused digits (index ≥ L) hold all-ones.
- States: IDLE, FILL, HOLD, DONE.
  - **IDLE**: when the trigger is high, latch L, clear the key to all-ones, set the digit index to 0, and go to FILL.
  - **FILL**: on each `data_valid`, write the digit at the current index and increment the index. After the write of index L-1, go to HOLD.
  - **FILL abort**: if the trigger drops during FILL, clear the key to all-ones, set `key_len` to 0 and return to IDLE. No `key_valid` is produced.
  - **HOLD**: `key_valid` is high. `sequence_key` and `key_len` must not change. On `key_valid && key_ready`, go to DONE.
  - **DONE**: the key is retained for display with `key_valid` low. Wait for the trigger to go low, then go to IDLE. This prevents a rebuild while the game stays in the sequence state.
- Trigger loss in HOLD does not abort; the handshake completes first.
- `data_valid` outside FILL is ignored.

## Timing
- Reset values:
  - `sequence_key` is all-ones.
  - `key_len`, `key_valid` and `busy` are 0.
  - State is IDLE and the digit index is 0.
- Trigger seen high at edge T: FILL from T+1. With continuous `data_valid` and no rejections, digits are written at edges T+1..T+L and `key_valid` is high from edge T+L.
- `key_valid` falls on the edge that samples `key_ready` high. `key_ready` may be high before `key_valid` rises; the transfer then takes one cycle of HOLD.
- Gaps in `data_valid` stall FILL with no timeout.
- Reset asserted in any state returns to the reset values immediately (asynchronously).

## Configuration
- `SEQKEY_NO_REPEAT_EN` defined:
  - In FILL, for index ≥ 1, a word whose symbol equals the previous digit's symbol is discarded. The index does not advance.
  - Digit 0 is never rejected.
- Not defined: every valid word is accepted, and repeats are allowed.

## Structure
- `bomb_pkg` holds:
  - the `GS_SEQUENCE` constant (7'h10);
  - the level encoding constants;
  - the state enum `seqkey_state_t`.
- Sub-module `symbol_onehot_low` is a combinational SYM_W → NUM_SYMBOLS encoder, instantiated once.
- The key register, the index counter and the FSM live in the top module.

## Test plan
All scenarios use default parameters.
- **Full-length key**: level 3, trigger, `data_in` 0,1,2,3 on consecutive valid cycles → `sequence_key` 16'hEDB7, `key_len` 4, `key_valid` at edge T+4.
- **Shortest key**: level 0, trigger, `data_in` 2 → `sequence_key` 16'hBFFF, `key_len` 1, `key_valid` after one digit.
- **Repeat rule**: level 3, `data_in` 1,1,2,3,0.
  - With `SEQKEY_NO_REPEAT_EN`: 16'hDB7E after 5 valid words.
  - Without: 16'hDDB7 after 4 words.
- **Backpressure**: `key_ready` held low 10 cycles in HOLD → key stable and `key_valid` high throughout. Raising `key_ready` drops `key_valid` next edge. The trigger held high afterwards produces no second key until it toggles low then high.
- **Mid-operation disturbances**:
  - Trigger dropped after 2 digits → key 16'hFFFF, `key_len` 0, IDLE.
  - `rst` pulsed mid-FILL → all outputs at reset values without waiting for an edge.
- **Stalls and ignored data**: `data_valid` gaps of 3 cycles between words → same key as continuous data. `data_valid` in IDLE/DONE leaves the key unchanged.
